wallace_mac_8: RTL

Pipelined 8x8 unsigned multiply-accumulate stage built around one wallace_8bit instance. It accepts a stream of operand pairs over a valid/ready handshake, registers operands ahead of the multiplier and registers the product after it, then accumulates products into a dot-product sum. The sum of each sequence (terminated by in_last) is presented on a valid/ready result port with term count and overflow flag. It sits between the operand source (coefficient/sample fetch) and the result consumer.

---
 rtl/wallace_mac_8.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/wallace_mac_8.sv
// wallace_8bit: exact 8x8 unsigned multiplier, Wallace-style carry-save reduction tree.
// Latency: combinational.
// Backpressure: none (pure function of a and b).
// Ports: a, b (8-bit operands) -> p (16-bit product a*b).
module wallace_8bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 3:2 compressor on whole vectors: sum bits and left-shifted carry bits.
  // Truncating the carry to 16 bits is harmless because the true product
  // always fits in 16 bits, so the arithmetic is exact modulo 2^16.
  function automatic logic [15:0] csa_sum(input logic [15:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, y, z);
    logic [15:0] m;
    m = (x & y) | (x & z) | (y & z);
    return {m[14:0], 1'b0};
  endfunction

  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1;   // level 1: 8 -> 6 rows
  logic [15:0] s2, c2, s3, c3;   // level 2: 6 -> 4 rows
  logic [15:0] s4, c4;           // level 3: 4 -> 3 rows
  logic [15:0] s5, c5;           // level 4: 3 -> 2 rows

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? ({8'd0, a} << i) : 16'd0;
    end
  end

  assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
  assign c0 = csa_carry(pp[0], pp[1], pp[2]);
  assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
  assign c1 = csa_carry(pp[3], pp[4], pp[5]);

  assign s2 = csa_sum  (s0, c0, s1);
  assign c2 = csa_carry(s0, c0, s1);
  assign s3 = csa_sum  (c1, pp[6], pp[7]);
  assign c3 = csa_carry(c1, pp[6], pp[7]);

  assign s4 = csa_sum  (s2, c2, s3);
  assign c4 = csa_carry(s2, c2, s3);

  assign s5 = csa_sum  (s4, c4, c3);
  assign c5 = csa_carry(s4, c4, c3);

  // Final carry-propagate adder.
  assign p = s5 + c5;

endmodule

// wallace_mac_8: pipelined 8x8 unsigned multiply-accumulate producing one dot-product
// sum per in_last-terminated sequence. Latency: last pair accepted at edge N -> out_valid
// after edge N+2; one pair per cycle. Backpressure: stall = out_valid & ~out_ready freezes
// every register; in_ready = ~stall.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_a/in_b/in_last operand stream;
// out_valid/out_ready/out_data/out_count/out_ovf result stream.
module wallace_mac_8 #(
  parameter int ACC_W    = 24,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic             stall;
  logic             s1_v, s1_last;
  logic [7:0]       s1_a, s1_b;
  logic             s2_v, s2_last;
  logic [15:0]      s2_prod;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] acc_base, acc_next;
  logic [CNT_W-1:0] cnt_base, cnt_next;
  logic             ovf_base, ovf_next;
  logic [ACC_W:0]   sum_full;
  logic             carry;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  wallace_8bit u_mult (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // Accumulate step. In IDLE the running values are ignored so a new sequence
  // starts from zero without needing a clearing cycle after the previous last.
  always_comb begin
    acc_base = (state == IDLE) ? '0 : acc;
    cnt_base = (state == IDLE) ? '0 : count;
    ovf_base = (state == IDLE) ? 1'b0 : ovf;
    sum_full = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, s2_prod};
    carry    = sum_full[ACC_W];
    ovf_next = ovf_base | carry;
    // An all-ones accumulator plus any non-zero product carries out again,
    // so a saturated sum stays pinned for the rest of the sequence.
    if (carry && (SATURATE != 0)) begin
      acc_next = '1;
    end else begin
      acc_next = sum_full[ACC_W-1:0];
    end
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_prod   <= '0;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means in_ready=1, so in_valid alone marks a transfer.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end

      s2_v <= s1_v;
      if (s1_v) begin
        s2_prod <= prod;
        s2_last <= s1_last;
      end

      if (s2_v) begin
        if (s2_last) begin
          out_data  <= acc_next;
          out_count <= cnt_next;
          out_ovf   <= ovf_next;
          state     <= IDLE;
        end else begin
          acc   <= acc_next;
          count <= cnt_next;
          ovf   <= ovf_next;
          state <= ACC;
        end
      end

      // Without a stall any held result is being consumed this edge, so
      // out_valid simply follows whether a new result is loaded.
      out_valid <= s2_v & s2_last;
    end
  end

endmodule
